// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - CPU, flash and tag/data table signals of the cache refill controller
interface cache_refill_ctrl_if #(
  parameter int WAYS   = 4,
  parameter int WORDS  = 4,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 18
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int ENT_W = TAG_W + AGE_W + 1;

  // CPU side
  logic                    miss;
  logic [ADDR_W-1:0]       miss_addr;
  logic                    hready_out;
  logic [31:0]             rdata;
  // flash_ctrl side
  logic                    req;
  logic [ADDR_W+1:0]       c_addr;
  logic                    ack;
  logic                    valid;
  logic [31:0]             data;
  // tag and data tables
  logic [WAYS*ENT_W-1:0]   tag_rd;
  logic [IDX_W-1:0]        set_idx;
  logic [WAYS-1:0]         data_we;
  logic [WORDS*32-1:0]     data_wdata;
  logic                    tag_we;
  logic [WAYS*ENT_W-1:0]   tag_wdata;

  // master: the refill controller
  modport master (
    input  miss, miss_addr, ack, valid, data, tag_rd,
    output hready_out, rdata, req, c_addr, set_idx, data_we, data_wdata, tag_we, tag_wdata
  );

  // slave: the CPU, flash_ctrl and tables around the controller
  modport slave (
    output miss, miss_addr, ack, valid, data, tag_rd,
    input  hready_out, rdata, req, c_addr, set_idx, data_we, data_wdata, tag_we, tag_wdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - line refill controller: fetch from flash, pick victim, write data and tags
module cache_refill_ctrl #(
  parameter int WAYS          = 4,
  parameter int WORDS         = 4,
  parameter int IDX_W         = 4,
  parameter int ADDR_W        = 18,
  parameter int EARLY_RESTART = 1
) (
  input  logic                hclk,
  input  logic                hreset_n,
  cache_refill_ctrl_if.master bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int ENT_W = TAG_W + AGE_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RECV    = 3'd2,
    S_WR_DATA = 3'd3,
    S_WR_TAG  = 3'd4
  } state_t;

  state_t                state;
  logic [TAG_W-1:0]      tag_q;
  logic [IDX_W-1:0]      idx_q;
  logic [OFF_W-1:0]      off_q;
  logic [AGE_W-1:0]      victim_q;
  logic [AGE_W-1:0]      old_age_q;
  logic [OFF_W-1:0]      beat_cnt;
  logic [31:0]           line_buf [WORDS];
  logic [31:0]           rdata_q;
  logic                  hready_q;
  logic                  req_q;
  logic [WAYS-1:0]       data_we_q;
  logic                  tag_we_q;
  logic [WAYS*ENT_W-1:0] tag_wdata_q;

  logic [AGE_W-1:0]      vic_sel;
  logic [AGE_W-1:0]      vic_age;
  logic [AGE_W-1:0]      inv_way;
  logic [AGE_W-1:0]      old_way;
  logic                  found_inv;
  logic                  found_old;
  logic [WAYS*ENT_W-1:0] new_tags;
  logic [WORDS*32-1:0]   line_flat;

  // Victim choice: an empty way first (lowest number), else the oldest way, else way 0
  always_comb begin
    found_inv = 1'b0;
    found_old = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !bus.tag_rd[w*ENT_W]) begin
        found_inv = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (!found_old && (bus.tag_rd[w*ENT_W+1 +: AGE_W] == AGE_W'(WAYS-1))) begin
        found_old = 1'b1;
        old_way   = AGE_W'(w);
      end
    end
    vic_sel = found_inv ? inv_way : (found_old ? old_way : '0);
    vic_age = bus.tag_rd[int'(vic_sel)*ENT_W+1 +: AGE_W];
  end

  // New set entries: victim becomes youngest, valid ways younger than its old age move one step older
  always_comb begin
    new_tags = bus.tag_rd;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == victim_q) begin
        new_tags[w*ENT_W +: ENT_W] = {tag_q, {AGE_W{1'b0}}, 1'b1};
      end else if (bus.tag_rd[w*ENT_W] && (bus.tag_rd[w*ENT_W+1 +: AGE_W] < old_age_q)) begin
        new_tags[w*ENT_W+1 +: AGE_W] = bus.tag_rd[w*ENT_W+1 +: AGE_W] + 1'b1;
      end
    end
  end

  // Flatten the line buffer onto the data-table write bus
  always_comb begin
    line_flat = '0;
    for (int k = 0; k < WORDS; k++) begin
      line_flat[k*32 +: 32] = line_buf[k];
    end
  end

  // Refill sequencer with registered handshake, strobe and CPU-release outputs
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= S_IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      victim_q    <= '0;
      old_age_q   <= '0;
      beat_cnt    <= '0;
      rdata_q     <= '0;
      hready_q    <= 1'b1;
      req_q       <= 1'b0;
      data_we_q   <= '0;
      tag_we_q    <= 1'b0;
      tag_wdata_q <= '0;
      for (int k = 0; k < WORDS; k++) begin
        line_buf[k] <= '0;
      end
    end else begin
      data_we_q <= '0;
      tag_we_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.miss) begin
            {tag_q, idx_q, off_q} <= bus.miss_addr;
            req_q    <= 1'b1;
            hready_q <= 1'b0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.ack) begin
            victim_q  <= vic_sel;
            old_age_q <= vic_age;
            req_q     <= 1'b0;
            beat_cnt  <= '0;
            state     <= S_RECV;
          end
        end
        S_RECV: begin
          if (bus.valid) begin
            line_buf[beat_cnt] <= bus.data;
            beat_cnt           <= beat_cnt + 1'b1;
            if (beat_cnt == off_q) begin
              rdata_q <= bus.data;
              if (EARLY_RESTART != 0) begin
                hready_q <= 1'b1;
              end
            end
            if (beat_cnt == OFF_W'(WORDS-1)) begin
              data_we_q <= WAYS'(1) << victim_q;
              state     <= S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          tag_we_q    <= 1'b1;
          tag_wdata_q <= new_tags;
          state       <= S_WR_TAG;
        end
        S_WR_TAG: begin
          if (EARLY_RESTART == 0) begin
            hready_q <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hready_out = hready_q;
  assign bus.rdata      = rdata_q;
  assign bus.req        = req_q;
  assign bus.c_addr     = {tag_q, idx_q, {OFF_W{1'b0}}, 2'b00};
  assign bus.set_idx    = idx_q;
  assign bus.data_we    = data_we_q;
  assign bus.data_wdata = line_flat;
  assign bus.tag_we     = tag_we_q;
  assign bus.tag_wdata  = tag_wdata_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed bench for cache_refill_ctrl, early and late restart side by side
module tb_cache_refill_ctrl;
  logic        hclk = 1'b0;
  logic        hreset_n = 1'b0;
  logic        miss = 1'b0;
  logic [17:0] miss_addr = '0;
  logic        ack = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = '0;
  logic [59:0] tag_rd = '0;
  logic [31:0] crit_data = 32'hFFFF_FFFF;

  int checks = 0;
  int fails = 0;

  always #5 hclk = ~hclk;

  cache_refill_ctrl_if u_if0 ();
  cache_refill_ctrl_if u_if1 ();

  assign u_if0.miss = miss;   assign u_if1.miss = miss;
  assign u_if0.miss_addr = miss_addr;   assign u_if1.miss_addr = miss_addr;
  assign u_if0.ack = ack;     assign u_if1.ack = ack;
  assign u_if0.valid = valid; assign u_if1.valid = valid;
  assign u_if0.data = data;   assign u_if1.data = data;
  assign u_if0.tag_rd = tag_rd;   assign u_if1.tag_rd = tag_rd;

  cache_refill_ctrl #(.EARLY_RESTART(1)) u_dut0 (.hclk(hclk), .hreset_n(hreset_n), .bus(u_if0.master));
  cache_refill_ctrl #(.EARLY_RESTART(0)) u_dut1 (.hclk(hclk), .hreset_n(hreset_n), .bus(u_if1.master));

  logic         m_hr [2];
  logic [31:0]  m_rd [2];
  logic         m_req [2];
  logic [19:0]  m_ca [2];
  logic [3:0]   m_si [2];
  logic [3:0]   m_dwe [2];
  logic [127:0] m_dwd [2];
  logic         m_twe [2];
  logic [59:0]  m_twd [2];
  assign m_hr[0] = u_if0.hready_out;  assign m_hr[1] = u_if1.hready_out;
  assign m_rd[0] = u_if0.rdata;       assign m_rd[1] = u_if1.rdata;
  assign m_req[0] = u_if0.req;        assign m_req[1] = u_if1.req;
  assign m_ca[0] = u_if0.c_addr;      assign m_ca[1] = u_if1.c_addr;
  assign m_si[0] = u_if0.set_idx;     assign m_si[1] = u_if1.set_idx;
  assign m_dwe[0] = u_if0.data_we;    assign m_dwe[1] = u_if1.data_we;
  assign m_dwd[0] = u_if0.data_wdata; assign m_dwd[1] = u_if1.data_wdata;
  assign m_twe[0] = u_if0.tag_we;     assign m_twe[1] = u_if1.tag_we;
  assign m_twd[0] = u_if0.tag_wdata;  assign m_twd[1] = u_if1.tag_wdata;

  // Monitor: sample mid-cycle and record strobe counts, captured payloads and event cycles
  int           cyc = 0;
  int           crit_cyc = 0;
  int           twe_cnt [2] = '{0, 0};
  int           dwe_cnt [2] = '{0, 0};
  int           req_cnt [2] = '{0, 0};
  int           twe_cyc [2] = '{0, 0};
  int           hr_rise [2] = '{0, 0};
  logic         hr_prev [2] = '{1'b1, 1'b1};
  logic [3:0]   dwe_cap [2];
  logic [127:0] dwd_cap [2];
  logic [59:0]  twd_cap [2];
  logic [19:0]  ca_cap [2];
  logic [3:0]   si_cap [2];

  always @(negedge hclk) begin
    cyc <= cyc + 1;
    if (valid && (data == crit_data)) crit_cyc <= cyc;
    for (int i = 0; i < 2; i++) begin
      if (m_twe[i]) begin
        twe_cnt[i] <= twe_cnt[i] + 1;
        twe_cyc[i] <= cyc;
        twd_cap[i] <= m_twd[i];
      end
      if (m_dwe[i] != 4'b0) begin
        dwe_cnt[i] <= dwe_cnt[i] + 1;
        dwe_cap[i] <= m_dwe[i];
        dwd_cap[i] <= m_dwd[i];
      end
      if (m_req[i]) begin
        req_cnt[i] <= req_cnt[i] + 1;
        ca_cap[i]  <= m_ca[i];
        si_cap[i]  <= m_si[i];
      end
      if (m_hr[i] && !hr_prev[i]) hr_rise[i] <= cyc;
      hr_prev[i] <= m_hr[i];
    end
  end

  function automatic logic [14:0] ent(input logic [11:0] t, input logic [1:0] a, input logic v);
    return {t, a, v};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic run_refill(input logic [17:0] addr, input int ack_dly, input int gap,
                            input bit stray, input logic [31:0] base, input int nbeats);
    crit_data = base + 32'(addr[1:0]);
    miss = 1'b1;
    miss_addr = addr;
    tick(1);
    miss = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      if (stray) begin
        valid = 1'b1;
        data = 32'h55 + 32'(i);
      end
      tick(1);
      valid = 1'b0;
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      valid = 1'b1;
      data = base + 32'(k);
      tick(1);
      valid = 1'b0;
      for (int g = 0; g < gap; g++) tick(1);
    end
    if (nbeats == 4) tick(5);
  endtask

  task automatic test_reset();
    hreset_n = 1'b0;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      checks++; if (m_hr[i] !== 1'b1) begin fails++; $display("FAIL reset_hready[%0d]: got %b expected 1", i, m_hr[i]); end
      checks++; if (m_req[i] !== 1'b0) begin fails++; $display("FAIL reset_req[%0d]: got %b expected 0", i, m_req[i]); end
      checks++; if (m_dwe[i] !== 4'b0) begin fails++; $display("FAIL reset_data_we[%0d]: got %b expected 0000", i, m_dwe[i]); end
      checks++; if (m_twe[i] !== 1'b0) begin fails++; $display("FAIL reset_tag_we[%0d]: got %b expected 0", i, m_twe[i]); end
      checks++; if (m_rd[i] !== 32'h0) begin fails++; $display("FAIL reset_rdata[%0d]: got %h expected 0", i, m_rd[i]); end
      checks++; if (m_dwd[i] !== 128'h0) begin fails++; $display("FAIL reset_line[%0d]: got %h expected 0", i, m_dwd[i]); end
    end
    hreset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_all_valid();
    logic [59:0] exp_t;
    int d0 [2];
    int t0 [2];
    tag_rd = {ent(12'h444, 2'd2, 1'b1), ent(12'h333, 2'd1, 1'b1), ent(12'h222, 2'd0, 1'b1), ent(12'h111, 2'd3, 1'b1)};
    exp_t  = {ent(12'h444, 2'd3, 1'b1), ent(12'h333, 2'd2, 1'b1), ent(12'h222, 2'd1, 1'b1), ent(12'h004, 2'd0, 1'b1)};
    d0 = dwe_cnt; t0 = twe_cnt;
    run_refill(18'h00125, 0, 0, 1'b0, 32'hA0, 4);
    for (int i = 0; i < 2; i++) begin
      checks++; if (ca_cap[i] !== 20'h00490) begin fails++; $display("FAIL allv_c_addr[%0d]: got %h expected 00490", i, ca_cap[i]); end
      checks++; if (si_cap[i] !== 4'h9) begin fails++; $display("FAIL allv_set_idx[%0d]: got %h expected 9", i, si_cap[i]); end
      checks++; if (dwe_cnt[i] - d0[i] !== 1) begin fails++; $display("FAIL allv_dwe_count[%0d]: got %0d expected 1", i, dwe_cnt[i] - d0[i]); end
      checks++; if (dwe_cap[i] !== 4'b0001) begin fails++; $display("FAIL allv_data_we[%0d]: got %b expected 0001", i, dwe_cap[i]); end
      checks++; if (dwd_cap[i] !== 128'h000000A3_000000A2_000000A1_000000A0) begin fails++; $display("FAIL allv_line[%0d]: got %h expected A3..A0", i, dwd_cap[i]); end
      checks++; if (twe_cnt[i] - t0[i] !== 1) begin fails++; $display("FAIL allv_twe_count[%0d]: got %0d expected 1", i, twe_cnt[i] - t0[i]); end
      checks++; if (twd_cap[i] !== exp_t) begin fails++; $display("FAIL allv_tag_wdata[%0d]: got %h expected %h", i, twd_cap[i], exp_t); end
      checks++; if (m_rd[i] !== 32'hA1) begin fails++; $display("FAIL allv_rdata[%0d]: got %h expected a1", i, m_rd[i]); end
    end
  endtask

  task automatic test_invalid_way();
    logic [59:0] exp_t;
    tag_rd = {ent(12'h444, 2'd3, 1'b1), ent(12'h333, 2'd1, 1'b0), ent(12'h222, 2'd0, 1'b1), ent(12'h111, 2'd2, 1'b1)};
    exp_t  = {ent(12'h444, 2'd3, 1'b1), ent(12'h2AD, 2'd0, 1'b1), ent(12'h222, 2'd1, 1'b1), ent(12'h111, 2'd2, 1'b1)};
    run_refill(18'h0AB40, 0, 1, 1'b0, 32'hC0, 4);
    for (int i = 0; i < 2; i++) begin
      checks++; if (ca_cap[i] !== 20'h2AD00) begin fails++; $display("FAIL inv_c_addr[%0d]: got %h expected 2ad00", i, ca_cap[i]); end
      checks++; if (si_cap[i] !== 4'h0) begin fails++; $display("FAIL inv_set_idx[%0d]: got %h expected 0", i, si_cap[i]); end
      checks++; if (dwe_cap[i] !== 4'b0100) begin fails++; $display("FAIL inv_data_we[%0d]: got %b expected 0100", i, dwe_cap[i]); end
      checks++; if (twd_cap[i] !== exp_t) begin fails++; $display("FAIL inv_tag_wdata[%0d]: got %h expected %h", i, twd_cap[i], exp_t); end
      checks++; if (m_rd[i] !== 32'hC0) begin fails++; $display("FAIL inv_rdata[%0d]: got %h expected c0", i, m_rd[i]); end
    end
  endtask

  task automatic test_restart();
    tag_rd = {ent(12'h444, 2'd2, 1'b1), ent(12'h333, 2'd1, 1'b1), ent(12'h222, 2'd0, 1'b1), ent(12'h111, 2'd3, 1'b1)};
    run_refill(18'h00126, 0, 2, 1'b0, 32'hA0, 4);
    for (int i = 0; i < 2; i++) begin
      checks++; if (m_rd[i] !== 32'hA2) begin fails++; $display("FAIL rst_rdata[%0d]: got %h expected a2", i, m_rd[i]); end
      checks++; if (dwd_cap[i] !== 128'h000000A3_000000A2_000000A1_000000A0) begin fails++; $display("FAIL rst_line[%0d]: got %h expected A3..A0", i, dwd_cap[i]); end
    end
    checks++; if (hr_rise[0] !== crit_cyc + 1) begin fails++; $display("FAIL early_hready_cycle: got %0d expected %0d", hr_rise[0], crit_cyc + 1); end
    checks++; if (!(hr_rise[0] < twe_cyc[0])) begin fails++; $display("FAIL early_before_tag_we: hready at %0d, tag_we at %0d", hr_rise[0], twe_cyc[0]); end
    checks++; if (hr_rise[1] !== twe_cyc[1] + 1) begin fails++; $display("FAIL late_hready_cycle: got %0d expected %0d", hr_rise[1], twe_cyc[1] + 1); end
  endtask

  task automatic test_ack_delay();
    logic [59:0] exp_t;
    int r0 [2];
    tag_rd = {ent(12'h444, 2'd2, 1'b1), ent(12'h333, 2'd1, 1'b1), ent(12'h222, 2'd0, 1'b1), ent(12'h111, 2'd3, 1'b1)};
    exp_t  = {ent(12'h444, 2'd3, 1'b1), ent(12'h333, 2'd2, 1'b1), ent(12'h222, 2'd1, 1'b1), ent(12'hFFF, 2'd0, 1'b1)};
    r0 = req_cnt;
    run_refill(18'h3FFFF, 5, 0, 1'b1, 32'hB0, 4);
    for (int i = 0; i < 2; i++) begin
      checks++; if (req_cnt[i] - r0[i] !== 6) begin fails++; $display("FAIL ackd_req_cycles[%0d]: got %0d expected 6", i, req_cnt[i] - r0[i]); end
      checks++; if (ca_cap[i] !== 20'hFFFF0) begin fails++; $display("FAIL ackd_c_addr[%0d]: got %h expected ffff0", i, ca_cap[i]); end
      checks++; if (si_cap[i] !== 4'hF) begin fails++; $display("FAIL ackd_set_idx[%0d]: got %h expected f", i, si_cap[i]); end
      checks++; if (dwd_cap[i] !== 128'h000000B3_000000B2_000000B1_000000B0) begin fails++; $display("FAIL ackd_line[%0d]: got %h expected B3..B0", i, dwd_cap[i]); end
      checks++; if (m_rd[i] !== 32'hB3) begin fails++; $display("FAIL ackd_rdata[%0d]: got %h expected b3", i, m_rd[i]); end
      checks++; if (twd_cap[i] !== exp_t) begin fails++; $display("FAIL ackd_tag_wdata[%0d]: got %h expected %h", i, twd_cap[i], exp_t); end
    end
  endtask

  task automatic test_reset_mid();
    logic [59:0] exp_t;
    int d0 [2];
    int t0 [2];
    tag_rd = {ent(12'h444, 2'd2, 1'b1), ent(12'h333, 2'd1, 1'b1), ent(12'h222, 2'd0, 1'b1), ent(12'h111, 2'd3, 1'b1)};
    exp_t  = {ent(12'h444, 2'd3, 1'b1), ent(12'h333, 2'd2, 1'b1), ent(12'h222, 2'd1, 1'b1), ent(12'h004, 2'd0, 1'b1)};
    d0 = dwe_cnt; t0 = twe_cnt;
    run_refill(18'h00124, 0, 0, 1'b0, 32'hD0, 2);
    hreset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (m_hr[i] !== 1'b1) begin fails++; $display("FAIL mid_hready[%0d]: got %b expected 1", i, m_hr[i]); end
      checks++; if (m_rd[i] !== 32'h0) begin fails++; $display("FAIL mid_rdata[%0d]: got %h expected 0", i, m_rd[i]); end
      checks++; if (m_dwd[i] !== 128'h0) begin fails++; $display("FAIL mid_line[%0d]: got %h expected 0", i, m_dwd[i]); end
    end
    tick(2);
    hreset_n = 1'b1;
    tick(6);
    for (int i = 0; i < 2; i++) begin
      checks++; if (dwe_cnt[i] !== d0[i]) begin fails++; $display("FAIL mid_no_data_we[%0d]: got %0d writes expected 0", i, dwe_cnt[i] - d0[i]); end
      checks++; if (twe_cnt[i] !== t0[i]) begin fails++; $display("FAIL mid_no_tag_we[%0d]: got %0d writes expected 0", i, twe_cnt[i] - t0[i]); end
    end
    run_refill(18'h00125, 0, 0, 1'b0, 32'hA0, 4);
    for (int i = 0; i < 2; i++) begin
      checks++; if (dwe_cnt[i] - d0[i] !== 1) begin fails++; $display("FAIL post_dwe_count[%0d]: got %0d expected 1", i, dwe_cnt[i] - d0[i]); end
      checks++; if (twd_cap[i] !== exp_t) begin fails++; $display("FAIL post_tag_wdata[%0d]: got %h expected %h", i, twd_cap[i], exp_t); end
      checks++; if (m_rd[i] !== 32'hA1) begin fails++; $display("FAIL post_rdata[%0d]: got %h expected a1", i, m_rd[i]); end
      checks++; if (m_hr[i] !== 1'b1) begin fails++; $display("FAIL post_hready[%0d]: got %b expected 1", i, m_hr[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_invalid_way();
    test_restart();
    test_ack_delay();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter WAYS, default 4: associativity; power of 2, range 2..8.
REQ-002 Parameter WORDS, default 4: 32-bit words per line; power of 2, range 2..8.
REQ-003 Parameter IDX_W, default 4: set index width.
REQ-004 Parameter ADDR_W, default 18: word-address width; derived OFF_W=log2(WORDS), AGE_W=log2(WAYS), TAG_W=ADDR_W-OFF_W-IDX_W, ENT_W=TAG_W+AGE_W+1.
REQ-005 Parameter EARLY_RESTART, default 1: 1 releases the CPU on the critical word; 0 releases it after the tag write.
REQ-006 Port hclk input 1: the single clock, all logic on its rising edge.
REQ-007 Port hreset_n input 1: asynchronous, active-low reset.
REQ-008 Port miss input 1: level miss request from the lookup stage.
REQ-009 Port miss_addr input ADDR_W: word address {tag, index, offset}.
REQ-010 Port hready_out output 1: CPU-side ready.
REQ-011 Port rdata output 32: critical word returned to the CPU.
REQ-012 Port req output 1: refill request to flash_ctrl.
REQ-013 Port c_addr output ADDR_W+2: line-aligned byte address to flash_ctrl.
REQ-014 Port ack input 1: flash_ctrl accepts req.
REQ-015 Port valid input 1: data beat strobe.
REQ-016 Port data input 32: beat payload.
REQ-017 Port tag_rd input WAYS*ENT_W: tag entries of the addressed set; way w at [w*ENT_W +: ENT_W] = {tag, age, vld}.
REQ-018 Port set_idx output IDX_W: set index for the tag/data tables.
REQ-019 Port data_we output WAYS: one-hot data-table write enable.
REQ-020 Port data_wdata output WORDS*32: line; word k at [k*32 +: 32].
REQ-021 Port tag_we output 1: writes all ways' entries of set_idx.
REQ-022 Port tag_wdata output WAYS*ENT_W: new entries, same packing as tag_rd.

Function
REQ-023 States: IDLE, REQ, RECV, WR_DATA, WR_TAG; encoded state register, no other states.
REQ-024 IDLE: miss=1 latches miss_addr, enters REQ, and hready_out=0 from the next cycle; miss is ignored in any other state.
REQ-025 REQ: req=1; on ack=1 latch victim and enter RECV; valid is ignored in REQ.
REQ-026 c_addr = {latched tag, latched index, OFF_W zeros, 2'b00}; set_idx = latched index; both stable from REQ through WR_TAG.
REQ-027 Victim = lowest-numbered way with vld=0; if all valid, the way with age=WAYS-1; if none matches, way 0.
REQ-028 RECV: each valid=1 writes data to word beat_cnt of the line buffer and increments beat_cnt (OFF_W bits, cleared on RECV entry); beats arrive in order 0..WORDS-1.
REQ-029 The beat with beat_cnt=WORDS-1 moves the block to WR_DATA the next cycle.
REQ-030 The beat whose index equals the latched offset loads rdata in the same edge.
REQ-031 EARLY_RESTART=1: hready_out=1 the cycle after the critical beat; EARLY_RESTART=0: hready_out=1 the cycle after WR_TAG.
REQ-032 WR_DATA: data_we = one-hot victim for exactly one cycle, data_wdata = the full line buffer.
REQ-033 WR_TAG: tag_we=1 for exactly one cycle, then IDLE.
REQ-034 Victim entry in WR_TAG: {latched tag, age 0, vld 1}.
REQ-035 Other ways in WR_TAG: valid ways with age below the victim's old age get age+1; all other fields unchanged; ages stay a permutation when the set was full.
REQ-036 data_we, tag_we and req are 0 in every state other than those named above.

Reset
REQ-037 hreset_n=0 at any time, including mid-refill, forces IDLE, beat_cnt=0, line buffer=0, rdata=0, hready_out=1, and req=data_we=tag_we=0 asynchronously.
REQ-038 No table write completes for a refill interrupted by reset.

Verification
REQ-039 WAYS=4, WORDS=4, set all valid, ages {3,0,1,2}; miss_addr=0x00125; 4 beats -> c_addr=0x00490, victim way0, tag_wdata ages {0,1,2,3}.
REQ-040 Way2 invalid, others valid -> data_we=4'b0100, only ways with age below way2's old age incremented.
REQ-041 EARLY_RESTART=1, offset=2, beats 0xA0..0xA3 with gaps -> rdata=0xA2, hready_out=1 one cycle after beat 2, before tag_we.
REQ-042 EARLY_RESTART=0, same stimulus -> hready_out=1 only in the cycle after tag_we.
REQ-043 ack delayed 5 cycles with valid pulses during REQ -> req held high for all 5, stray beats ignored, beat_cnt=0 on RECV entry.
REQ-044 hreset_n low after beat 1 -> IDLE, hready_out=1, no data_we/tag_we; a following miss completes a normal refill.
